// File: rtl/piso_stream_pkg.sv
// Shared x25519 streaming definitions: default block geometry and the
// parallel-to-serial FSM state encoding.
package piso_stream_pkg;

    localparam int unsigned DEF_R_DATA_WIDTH = 32;
    localparam int unsigned DEF_N_REG        = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } piso_state_t;

    // A single-word block still needs a 1-bit index so port widths stay legal.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_stream.sv
// Captures a wide parallel block in one cycle and streams it out LSB word
// first under a valid/ready handshake; all outputs come straight from flops.
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int unsigned R_DATA_WIDTH = DEF_R_DATA_WIDTH,
    parameter int unsigned N_REG        = DEF_N_REG,
    parameter int unsigned N_REG_BITS   = idx_bits(N_REG)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [R_DATA_WIDTH*N_REG-1:0]  din,
    output logic [R_DATA_WIDTH-1:0]        dout,
    output logic [N_REG_BITS-1:0]          dout_addr,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic                           dout_last,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned BLK_W = R_DATA_WIDTH * N_REG;
    localparam logic [N_REG_BITS-1:0] LAST_IDX = N_REG_BITS'(N_REG - 1);

    piso_state_t             state_q;
    logic [BLK_W-1:0]        shadow_q;
    logic [BLK_W-1:0]        shadow_d;
    logic [R_DATA_WIDTH-1:0] dout_q;
    logic [N_REG_BITS-1:0]   addr_q;
    logic [N_REG_BITS-1:0]   addr_d;
    logic                    last_q;
    logic                    done_q;

    // The shadow is consumed by shifting, so the next word is always at the
    // bottom and no wide output mux is needed.
    assign shadow_d = shadow_q >> R_DATA_WIDTH;
    assign addr_d   = addr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            dout_q   <= '0;
            addr_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shadow_q <= din;
                        dout_q   <= din[R_DATA_WIDTH-1:0];
                        addr_q   <= '0;
                        last_q   <= (LAST_IDX == '0);
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (dout_ready) begin
                        if (addr_q == LAST_IDX) begin
                            addr_q  <= '0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            shadow_q <= shadow_d;
                            dout_q   <= shadow_d[R_DATA_WIDTH-1:0];
                            addr_q   <= addr_d;
                            last_q   <= (addr_d == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_addr  = addr_q;
    assign dout_valid = (state_q == ST_SEND);
    assign busy       = (state_q == ST_SEND);
    assign dout_last  = last_q;
    assign done       = done_q;

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Downstream companion of the X25519 SIPO input register: captures a wide parallel result (e.g. 256-bit u-coordinate) in one cycle and streams it out as R_DATA_WIDTH-bit words under a valid/ready handshake to the host bus interface.
- Word 0 is the least-significant slice (bits R_DATA_WIDTH-1:0). This is the same word/address mapping the SIPO uses on input, so data round-trips unchanged.

Parameters:
- R_DATA_WIDTH, 32, width of one output word.
- N_REG, 8, number of words per parallel block.
- N_REG_BITS, $clog2(N_REG), width of the word index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  capture din and begin streaming; honoured only when busy=0.
- din  input  R_DATA_WIDTH*N_REG  parallel data block.
- dout  output  R_DATA_WIDTH  current word.
- dout_addr  output  N_REG_BITS  index of current word.
- dout_valid  output  1  dout/dout_addr/dout_last valid.
- dout_ready  input  1  consumer accepts word when dout_valid=1.
- dout_last  output  1  current word is index N_REG-1.
- busy  output  1  block captured and not yet fully sent.
- done  output  1  one-cycle pulse after final word accepted.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; shadow register=0; dout=0, dout_addr=0, dout_valid=0, dout_last=0, busy=0, done=0. Reset mid-stream aborts immediately and does not pulse done.
- FSM states:
  - IDLE: busy=0, dout_valid=0.
  - SEND: busy=1, dout_valid=1.
- IDLE with start=1 at edge t:
  - shadow <= din; index <= 0; state <= SEND.
  - From cycle t+1: dout_valid=1, dout=din[R_DATA_WIDTH-1:0], dout_addr=0. Latency start->first word = 1 cycle.
- SEND: dout = shadow[R_DATA_WIDTH*index +: R_DATA_WIDTH], driven from registers (no combinational path from dout_ready to dout).
  - dout_valid stays high and dout/dout_addr stay stable until a handshake (dout_valid & dout_ready) occurs.
  - Handshake with index<N_REG-1: index increments; the next word appears the following cycle. Back-to-back handshakes give one word per cycle.
  - Handshake with index=N_REG-1: state <= IDLE; index <= 0; dout_valid deasserts next cycle; done=1 for exactly that next cycle.
- dout_last = dout_valid & (dout_addr==N_REG-1).
- start while busy=1 is ignored; shadow and stream are unaffected, and there is no error flag.
- Cycle where done=1: state is IDLE, so a start in that cycle is accepted. Its first word appears on the following cycle.
- din is sampled only on the accepted start edge; later changes to din have no effect.
- dout_ready while dout_valid=0 is ignored.
- N_REG=1: one handshake ends the stream, and dout_last is high on that word.
- dout may retain its last value in IDLE; consumers qualify with dout_valid.

Decomposition:
- Shared x25519 package: state encoding localparams (ST_IDLE, ST_SEND) and the default R_DATA_WIDTH/N_REG constants shared with the SIPO.
- Single module: FSM, word-index counter and output mux fit inline. No sub-module.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles with start=1 and din=all ones -> all outputs 0 throughout; after rst=1 with start=0, dout_valid stays 0.
- Full-rate stream: din={32'h7,...,32'h0} (word i = i), start one cycle, dout_ready=1 -> dout=0..7 on 8 consecutive cycles from start+1; dout_last only on word 7; done pulses at start+9; busy high start+1..start+8.
- Backpressure: same block, dout_ready toggling 1,0,0,1,... -> each word is held stable while ready=0, none lost or duplicated, and the sequence is still 0..7 in order.
- Ignored start: mid-stream at word 3, pulse start with din=all 0xA5A5A5A5 -> remaining words are 3..7 of the original block; no restart.
- Back-to-back blocks: assert start in the done cycle with din word i = 0x100+i -> first word 0x100 appears the next cycle and the second stream completes normally.
- Reset mid-operation: drive rst=0 at word 5 -> next cycle dout_valid=0, busy=0, done=0; a new start then streams from word 0.
